my_stack: RTL and testbench
===========================

MY_STACK -- requirements
Module: my_stack

Interface
REQ-001 Parameter PC_WIDTH, default 8: width of program-counter values held on the stack.
REQ-002 Parameter OPCODE_WIDTH, default 4: width of reset_code.
REQ-003 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, minimum 2.
REQ-004 Parameters CALL_CODE = 4'h1, RET_CODE = 4'h2, RST_CODE = 4'hF (OPCODE_WIDTH wide): opcode encodings decoded by the block.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high. Port clock, input, 1 bit, rising-edge clock; port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 Port reset_code, input, OPCODE_WIDTH bits: current instruction opcode, or RST_CODE when a soft reset is requested.
REQ-007 Port called_from, input, PC_WIDTH bits: current program counter.
REQ-008 Port return_to, output, PC_WIDTH bits: top-of-stack return address.
REQ-009 Port depth, output, clog2(DEPTH)+1 bits: number of valid entries.
REQ-010 Port empty, output, 1 bit: depth == 0.
REQ-011 Port full, output, 1 bit: depth == DEPTH.
REQ-012 Port overflow, output, 1 bit: sticky push-when-full flag.
REQ-013 Port underflow, output, 1 bit: sticky pop-when-empty flag.

Function
REQ-014 Push on a clock edge with reset_code == CALL_CODE: write (called_from + 1) mod 2^PC_WIDTH into the entry above the current top; depth increments.
REQ-015 Pop on a clock edge with reset_code == RET_CODE: depth decrements; the popped entry is not cleared.
REQ-016 Soft reset on a clock edge with reset_code == RST_CODE: depth becomes 0, and overflow and underflow clear.
REQ-017 Any other opcode: no state change.
REQ-018 return_to SHALL be combinational from the current top entry, valid in the same cycle, so the PC loads it on the RET edge; when empty, return_to = 0.
REQ-019 empty, full and depth are combinational from state; latency of push and pop is one edge.
REQ-020 Only one operation per cycle is possible, because the opcode is a single value.
REQ-021 Storage is a DEPTH-entry register array indexed by a pointer of clog2(DEPTH) bits plus a full indicator.

Reset
REQ-022 While reset is high: depth = 0, overflow = 0, underflow = 0, return_to = 0, empty = 1, full = 0.
REQ-023 Array contents are not required to reset.
REQ-024 Reset takes effect immediately, independent of clock; on release, the first active edge is processed normally.
REQ-025 Reset asserted mid-sequence discards all entries.

Configuration
REQ-026 Macro MY_STACK_GUARD_EN defined: push when full is ignored (contents and depth unchanged) and sets overflow; pop when empty is ignored (depth stays 0) and sets underflow.
REQ-027 Macro MY_STACK_GUARD_EN undefined: the pointer wraps modulo DEPTH.
- Push when full overwrites the oldest entry, and depth stays DEPTH.
- Pop when empty leaves depth 0.
- overflow and underflow are tied to 0.

Verification
REQ-028 Reset, then CALL with called_from = 8'h10 -> depth = 1, return_to = 8'h11; then RET -> depth = 0, empty = 1, return_to = 0.
REQ-029 Nested CALLs at 8'h05, 8'h20, 8'h40 -> return_to = 8'h41; successive RETs show 8'h21, then 8'h06, then empty.
REQ-030 CALL with called_from = 8'hFF -> return_to = 8'h00 (address wrap).
REQ-031 Seventeen CALLs at 0..16 with guard enabled -> full = 1, overflow = 1, return_to = 8'h10; RST_CODE -> depth = 0, flags cleared.
REQ-032 RET on empty stack -> underflow = 1 with guard; with guard disabled, depth = 0 and underflow = 0.
REQ-033 Reset asserted asynchronously mid-cycle after three pushes -> depth = 0 and empty = 1 before the next clock edge.

Source files
------------

// File: rtl/my_stack.sv
// my_stack: hardware return-address stack for CALL/RET.
// A CALL pushes called_from+1. A RET pops the top entry. The RST opcode empties the stack.
// return_to, depth, empty and full are decoded combinationally from the current state.
// The MY_STACK_GUARD_EN macro selects the behaviour when the stack is full or empty:
//   - defined: a push to a full stack or a pop from an empty stack is ignored,
//     and the matching sticky flag (overflow or underflow) is set.
//   - undefined: the write pointer wraps, so a push to a full stack overwrites
//     the oldest entry. overflow and underflow are held at 0.
module my_stack #(
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned DEPTH        = 16,
  parameter logic [OPCODE_WIDTH-1:0] CALL_CODE = OPCODE_WIDTH'(4'h1),
  parameter logic [OPCODE_WIDTH-1:0] RET_CODE  = OPCODE_WIDTH'(4'h2),
  parameter logic [OPCODE_WIDTH-1:0] RST_CODE  = OPCODE_WIDTH'(4'hF)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [OPCODE_WIDTH-1:0]   reset_code,
  input  logic [PC_WIDTH-1:0]       called_from,
  output logic [PC_WIDTH-1:0]       return_to,
  output logic [$clog2(DEPTH):0]    depth,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;
  localparam logic [DW-1:0] DEPTH_VAL = DW'(DEPTH);

  // Entry storage; contents are not reset, only the pointer and count are.
  logic [PC_WIDTH-1:0] mem [DEPTH];

  // ptr_q points at the next free slot (circular); cnt_q holds the occupancy.
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;
  logic [AW-1:0] top_idx;
  logic          wr_en;
  logic          is_empty;
  logic          is_full;

`ifdef MY_STACK_GUARD_EN
  logic ovf_q;
  logic ovf_d;
  logic unf_q;
  logic unf_d;
`endif

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == DEPTH_VAL);
  assign top_idx  = ptr_q - AW'(1);

  // Status outputs and the top-of-stack address, decoded from the current state.
  assign depth     = cnt_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign return_to = is_empty ? '0 : mem[top_idx];

`ifdef MY_STACK_GUARD_EN
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // Decode the opcode into a next pointer, next count and a write strobe.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
`ifdef MY_STACK_GUARD_EN
    ovf_d = ovf_q;
    unf_d = unf_q;
`endif
    if (reset_code == RST_CODE) begin
      ptr_d = '0;
      cnt_d = '0;
`ifdef MY_STACK_GUARD_EN
      ovf_d = 1'b0;
      unf_d = 1'b0;
`endif
    end else if (reset_code == CALL_CODE) begin
      if (is_full) begin
`ifdef MY_STACK_GUARD_EN
        ovf_d = 1'b1;
`else
        // The slot at ptr_q holds the oldest entry once wrapped; replace it.
        wr_en = 1'b1;
        ptr_d = ptr_q + AW'(1);
`endif
      end else begin
        wr_en = 1'b1;
        ptr_d = ptr_q + AW'(1);
        cnt_d = cnt_q + DW'(1);
      end
    end else if (reset_code == RET_CODE) begin
      if (is_empty) begin
`ifdef MY_STACK_GUARD_EN
        unf_d = 1'b1;
`endif
      end else begin
        ptr_d = ptr_q - AW'(1);
        cnt_d = cnt_q - DW'(1);
      end
    end
  end

  // Pointer, count and flag registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
`ifdef MY_STACK_GUARD_EN
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`endif
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
`ifdef MY_STACK_GUARD_EN
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`endif
    end
  end

  // Write the return address (caller PC + 1, wrapping) into the free slot.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[ptr_q] <= called_from + PC_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_my_stack.sv
// Directed self-checking bench for my_stack (default parameters).
// Expectations follow MY_STACK_GUARD_EN, so the same bench serves both builds.
module tb_my_stack;

  localparam logic [3:0] CALL = 4'h1;
  localparam logic [3:0] RET  = 4'h2;
  localparam logic [3:0] RST  = 4'hF;
  localparam logic [3:0] NOP  = 4'h0;

  logic       clock;
  logic       reset;
  logic [3:0] reset_code;
  logic [7:0] called_from;
  logic [7:0] return_to;
  logic [4:0] depth;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int checks;
  int errors;

  my_stack dut (
    .clock       (clock),
    .reset       (reset),
    .reset_code  (reset_code),
    .called_from (called_from),
    .return_to   (return_to),
    .depth       (depth),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one opcode across a rising edge; outputs settle 1 time unit later.
  task automatic op(input logic [3:0] code, input logic [7:0] pc);
    @(negedge clock);
    reset_code  = code;
    called_from = pc;
    @(posedge clock);
    #1;
    reset_code  = NOP;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    reset_code = NOP;
    called_from = 8'h00;
    #12;
    checks++; if (depth !== 5'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", depth); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (return_to !== 8'h00) begin errors++; $display("FAIL reset_return_to got %h exp 00", return_to); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, underflow}); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_call;
    op(CALL, 8'h10);
    checks++; if (depth !== 5'd1) begin errors++; $display("FAIL call_depth got %0d exp 1", depth); end
    checks++; if (return_to !== 8'h11) begin errors++; $display("FAIL call_return_to got %h exp 11", return_to); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL call_empty got %b exp 0", empty); end
    // A non-stack opcode must leave everything untouched.
    op(NOP, 8'h77);
    checks++; if (depth !== 5'd1 || return_to !== 8'h11) begin errors++; $display("FAIL nop_hold got depth %0d rt %h exp 1 11", depth, return_to); end
    op(RET, 8'h00);
    checks++; if (depth !== 5'd0) begin errors++; $display("FAIL ret_depth got %0d exp 0", depth); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b exp 1", empty); end
    checks++; if (return_to !== 8'h00) begin errors++; $display("FAIL ret_return_to got %h exp 00", return_to); end
  endtask

  task automatic test_nested;
    op(CALL, 8'h05);
    op(CALL, 8'h20);
    op(CALL, 8'h40);
    checks++; if (return_to !== 8'h41 || depth !== 5'd3) begin errors++; $display("FAIL nest_top got rt %h depth %0d exp 41 3", return_to, depth); end
    // The top must be visible during the RET cycle itself, before the edge.
    @(negedge clock);
    reset_code = RET;
    #1;
    checks++; if (return_to !== 8'h41) begin errors++; $display("FAIL nest_same_cycle got %h exp 41", return_to); end
    @(posedge clock);
    #1;
    reset_code = NOP;
    checks++; if (return_to !== 8'h21 || depth !== 5'd2) begin errors++; $display("FAIL nest_ret1 got rt %h depth %0d exp 21 2", return_to, depth); end
    op(RET, 8'h00);
    checks++; if (return_to !== 8'h06 || depth !== 5'd1) begin errors++; $display("FAIL nest_ret2 got rt %h depth %0d exp 06 1", return_to, depth); end
    op(RET, 8'h00);
    checks++; if (empty !== 1'b1 || return_to !== 8'h00) begin errors++; $display("FAIL nest_ret3 got empty %b rt %h exp 1 00", empty, return_to); end
  endtask

  task automatic test_addr_wrap;
    op(CALL, 8'hFF);
    checks++; if (return_to !== 8'h00 || depth !== 5'd1) begin errors++; $display("FAIL addr_wrap got rt %h depth %0d exp 00 1", return_to, depth); end
    op(RST, 8'h00);
    checks++; if (depth !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL soft_rst got depth %0d empty %b exp 0 1", depth, empty); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 16; i++) op(CALL, 8'(i));
    checks++; if (full !== 1'b1 || depth !== 5'd16) begin errors++; $display("FAIL full16 got full %b depth %0d exp 1 16", full, depth); end
    checks++; if (return_to !== 8'h10) begin errors++; $display("FAIL full16_top got %h exp 10", return_to); end
    op(CALL, 8'h10);
    checks++; if (full !== 1'b1 || depth !== 5'd16) begin errors++; $display("FAIL push_full got full %b depth %0d exp 1 16", full, depth); end
`ifdef MY_STACK_GUARD_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b exp 1", overflow); end
    checks++; if (return_to !== 8'h10) begin errors++; $display("FAIL push_full_top got %h exp 10", return_to); end
    op(RET, 8'h00);
    checks++; if (return_to !== 8'h0F || depth !== 5'd15) begin errors++; $display("FAIL full_pop got rt %h depth %0d exp 0f 15", return_to, depth); end
`else
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow got %b exp 0", overflow); end
    checks++; if (return_to !== 8'h11) begin errors++; $display("FAIL push_full_top got %h exp 11", return_to); end
    op(RET, 8'h00);
    checks++; if (return_to !== 8'h10 || depth !== 5'd15) begin errors++; $display("FAIL full_pop got rt %h depth %0d exp 10 15", return_to, depth); end
`endif
    op(RST, 8'h00);
    checks++; if (depth !== 5'd0 || full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL full_rst got depth %0d full %b ovf %b exp 0 0 0", depth, full, overflow); end
  endtask

  task automatic test_underflow;
    op(RET, 8'h00);
    checks++; if (depth !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL pop_empty got depth %0d empty %b exp 0 1", depth, empty); end
`ifdef MY_STACK_GUARD_EN
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow got %b exp 1", underflow); end
`else
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow got %b exp 0", underflow); end
`endif
    // The stack must still work normally after an empty pop.
    op(CALL, 8'h30);
    checks++; if (return_to !== 8'h31 || depth !== 5'd1) begin errors++; $display("FAIL after_underflow got rt %h depth %0d exp 31 1", return_to, depth); end
    op(RST, 8'h00);
    checks++; if (underflow !== 1'b0 || depth !== 5'd0) begin errors++; $display("FAIL underflow_clr got unf %b depth %0d exp 0 0", underflow, depth); end
  endtask

  task automatic test_async_reset;
    op(CALL, 8'h01);
    op(CALL, 8'h02);
    op(CALL, 8'h03);
    checks++; if (depth !== 5'd3) begin errors++; $display("FAIL pre_async got %0d exp 3", depth); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (depth !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL async_rst got depth %0d empty %b exp 0 1", depth, empty); end
    checks++; if (return_to !== 8'h00) begin errors++; $display("FAIL async_rst_rt got %h exp 00", return_to); end
    @(negedge clock);
    reset = 1'b0;
    op(CALL, 8'h50);
    checks++; if (depth !== 5'd1 || return_to !== 8'h51) begin errors++; $display("FAIL post_reset got depth %0d rt %h exp 1 51", depth, return_to); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_call();
    test_nested();
    test_addr_wrap();
    test_full();
    test_underflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
